// File: rtl/fb_fill_arbiter_if.sv
// Frame-buffer fill/arbiter bus bundle: config register port, CPU store port
// and the shared frame-buffer write port.
// master: the surrounding system (CPU + frame buffer); slave: fb_fill_arbiter.
interface fb_fill_arbiter_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int DATA_W = 32
);
  // Config register port
  logic                 cfg_we;
  logic [2:0]           cfg_addr;
  logic [31:0]          cfg_wdata;
  logic [31:0]          cfg_rdata;

  // CPU frame-buffer store port
  logic                 cpu_fb_we;
  logic [X_W+Y_W-1:0]   cpu_fb_addr;
  logic [DATA_W-1:0]    cpu_fb_wdata;
  logic                 cpu_fb_stall;

  // Shared frame-buffer write port
  logic                 fb_valid;
  logic [X_W+Y_W-1:0]   fb_addr;
  logic [DATA_W-1:0]    fb_wdata;
  logic                 fb_ready;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata,
    output cpu_fb_we, cpu_fb_addr, cpu_fb_wdata,
    input  cpu_fb_stall,
    input  fb_valid, fb_addr, fb_wdata,
    output fb_ready
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata,
    input  cpu_fb_we, cpu_fb_addr, cpu_fb_wdata,
    output cpu_fb_stall,
    output fb_valid, fb_addr, fb_wdata,
    input  fb_ready
  );
endinterface

// File: rtl/fb_fill_arbiter.sv
// Rectangle-fill engine sharing one frame-buffer write port with CPU stores.
// CPU configures X0/Y0/X1/Y1/COLOR, writes CTRL.go, and the engine streams
// {y,x} pixel writes in raster order. A lock keeps the owner of an unaccepted
// beat on the port until fb_ready.
// Optional macro FB_FILL_FAIR_EN: round-robin CPU/engine arbitration instead
// of strict CPU priority.
module fb_fill_arbiter #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  fb_fill_arbiter_if.slave bus,
  output logic             busy,
  output logic             done_irq
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FILL,
    DONE
  } state_t;

  state_t state, state_next;

  logic [X_W-1:0]    x0_q, x1_q, x_q;
  logic [Y_W-1:0]    y0_q, y1_q, y_q;
  logic [DATA_W-1:0] color_q;

  logic done_q;
  logic aborted_q;
  logic abort_pend_q;
  logic lock_q;
  logic lock_cpu_q;

  logic ctrl_wr;
  logic go_now;
  logic abort_now;
  logic abort_any;
  logic cfg_reg_wr;
  logic eng_req;
  logic cpu_req;
  logic eng_grant;
  logic cpu_grant;
  logic eng_acc;
  logic cpu_acc;
  logic last_pixel;
  logic eng_locked;
  logic abort_exit;

`ifdef FB_FILL_FAIR_EN
  logic prio_eng_q;
`endif

  assign busy       = (state != IDLE);
  assign done_irq   = (state == DONE);

  assign ctrl_wr    = bus.cfg_we && (bus.cfg_addr == 3'd5);
  assign go_now     = ctrl_wr && bus.cfg_wdata[0];
  assign abort_now  = ctrl_wr && bus.cfg_wdata[1];
  assign abort_any  = abort_now || abort_pend_q;
  assign cfg_reg_wr = bus.cfg_we && !busy && (bus.cfg_addr < 3'd5);

  assign eng_locked = lock_q && !lock_cpu_q;
  assign last_pixel = (x_q == x1_q) && (y_q == y1_q);

  // Once abort is seen the engine stops requesting, except to finish a beat
  // it already holds the lock for.
  assign eng_req    = rst && (state == FILL) && (!abort_any || eng_locked);
  assign cpu_req    = rst && bus.cpu_fb_we;

  // Port ownership: locked owner first, otherwise CPU priority (or round-robin)
  always_comb begin
    cpu_grant = 1'b0;
    eng_grant = 1'b0;
    if (lock_q) begin
      cpu_grant = lock_cpu_q && cpu_req;
      eng_grant = !lock_cpu_q && eng_req;
    end else begin
`ifdef FB_FILL_FAIR_EN
      if (cpu_req && eng_req) begin
        eng_grant = prio_eng_q;
        cpu_grant = !prio_eng_q;
      end else begin
        cpu_grant = cpu_req;
        eng_grant = eng_req;
      end
`else
      cpu_grant = cpu_req;
      eng_grant = eng_req && !cpu_req;
`endif
    end
  end

  assign eng_acc = eng_grant && bus.fb_ready;
  assign cpu_acc = cpu_grant && bus.fb_ready;

  // Frame-buffer port mux of the current owner's request
  always_comb begin
    bus.fb_valid     = cpu_grant || eng_grant;
    bus.fb_addr      = {y_q, x_q};
    bus.fb_wdata     = color_q;
    bus.cpu_fb_stall = bus.cpu_fb_we && !cpu_acc;
    if (cpu_grant) begin
      bus.fb_addr  = bus.cpu_fb_addr;
      bus.fb_wdata = bus.cpu_fb_wdata;
    end
  end

  // Hold ownership while a presented beat is not accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q     <= 1'b0;
      lock_cpu_q <= 1'b0;
    end else begin
      lock_q     <= bus.fb_valid && !bus.fb_ready;
      lock_cpu_q <= cpu_grant;
    end
  end

`ifdef FB_FILL_FAIR_EN
  // Round-robin pointer: favour whoever did not win the last accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_eng_q <= 1'b0;
    end else if (cpu_acc) begin
      prio_eng_q <= 1'b1;
    end else if (eng_acc) begin
      prio_eng_q <= 1'b0;
    end
  end
`endif

  // Engine state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Engine next-state logic and abort bookkeeping
  always_comb begin
    state_next = state;
    abort_exit = 1'b0;
    case (state)
      IDLE: begin
        if (go_now) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (abort_now) begin
          state_next = IDLE;
          abort_exit = 1'b1;
        end else if ((x1_q < x0_q) || (y1_q < y0_q)) begin
          state_next = DONE;
        end else begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (abort_any) begin
          // A locked engine beat must drain before the engine lets go.
          if (!(eng_locked && !bus.fb_ready)) begin
            state_next = IDLE;
            abort_exit = 1'b1;
          end
        end else if (eng_acc && last_pixel) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Raster position: load on CHECK, advance on every accepted engine beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state == CHECK) begin
      x_q <= x0_q;
      y_q <= y0_q;
    end else if (eng_acc) begin
      if (x_q == x1_q) begin
        x_q <= x0_q;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  // Sticky status flags and the deferred-abort marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      abort_pend_q <= (state == FILL) && (state_next == FILL) && abort_any;
      if ((state == IDLE) && go_now) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end else begin
        if (state == DONE) begin
          done_q <= 1'b1;
        end
        if (abort_exit) begin
          aborted_q <= 1'b1;
        end
      end
    end
  end

  // Rectangle and colour registers, writable only while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (cfg_reg_wr) begin
      case (bus.cfg_addr)
        3'd0:    x0_q    <= X_W'(bus.cfg_wdata);
        3'd1:    y0_q    <= Y_W'(bus.cfg_wdata);
        3'd2:    x1_q    <= X_W'(bus.cfg_wdata);
        3'd3:    y1_q    <= Y_W'(bus.cfg_wdata);
        3'd4:    color_q <= DATA_W'(bus.cfg_wdata);
        default: ;
      endcase
    end
  end

  // Combinational register read-back
  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      3'd0:    bus.cfg_rdata = 32'(x0_q);
      3'd1:    bus.cfg_rdata = 32'(y0_q);
      3'd2:    bus.cfg_rdata = 32'(x1_q);
      3'd3:    bus.cfg_rdata = 32'(y1_q);
      3'd4:    bus.cfg_rdata = 32'(color_q);
      3'd5:    bus.cfg_rdata = {29'b0, aborted_q, done_q, busy};
      default: bus.cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Self-checking bench for fb_fill_arbiter: directed scenarios followed by
// randomized fills with random fb_ready and CPU stores, checked against a
// pixel-list reference built from the rectangle bounds.
module tb_fb_fill_arbiter;
  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic done_irq;

  fb_fill_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) bus ();

  fb_fill_arbiter #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  int          errors  = 0;
  int          checks  = 0;
  int          cyc     = 0;
  int          done_at = -1;
  int          eng_cnt = 0;
  int          cpu_cnt = 0;
  int unsigned exp_pix[$];
  logic [31:0] exp_color = '0;
  logic        prev_pend = 1'b0;
  logic [19:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  bit          rand_on   = 1'b0;
  int unsigned ready_pct = 100;
  int unsigned cpu_pct   = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, advance, then drive new random inputs.
  task automatic tick();
    logic        beat;
    logic        cacc;
    int unsigned e;
    @(negedge clk);
    beat = bus.fb_valid && bus.fb_ready;
    cacc = rst && bus.cpu_fb_we && !bus.cpu_fb_stall;
    chk("done_irq", done_irq, (cyc == done_at));
    if (prev_pend) begin
      chk("hold_valid", bus.fb_valid, 1'b1);
      chk("hold_addr", bus.fb_addr, prev_addr);
      chk("hold_data", bus.fb_wdata, prev_data);
    end
    if (bus.cpu_fb_we && !bus.fb_ready)
      chk("stall_not_ready", bus.cpu_fb_stall, 1'b1);
`ifndef FB_FILL_FAIR_EN
    if (rst && bus.cpu_fb_we && !prev_pend)
      chk("cpu_priority", bus.cpu_fb_stall, !bus.fb_ready);
`endif
    if (cacc) begin
      chk("cpu_beat_valid", bus.fb_valid, 1'b1);
      chk("cpu_beat_addr", bus.fb_addr, bus.cpu_fb_addr);
      chk("cpu_beat_data", bus.fb_wdata, bus.cpu_fb_wdata);
      cpu_cnt++;
    end else if (beat) begin
      if (exp_pix.size() == 0) begin
        chk("eng_extra_beat", 1'b1, 1'b0);
      end else begin
        e = exp_pix.pop_front();
        chk("eng_addr", bus.fb_addr, e);
        chk("eng_data", bus.fb_wdata, exp_color);
        if (exp_pix.size() == 0) done_at = cyc + 1;
      end
      eng_cnt++;
    end
    prev_pend = rst && bus.fb_valid && !bus.fb_ready;
    prev_addr = bus.fb_addr;
    prev_data = bus.fb_wdata;
    @(posedge clk);
    #1;
    cyc++;
    if (cacc) bus.cpu_fb_we = 1'b0;
    if (rand_on) begin
      bus.fb_ready = ($urandom_range(99) < ready_pct);
      if (!bus.cpu_fb_we && ($urandom_range(99) < cpu_pct)) begin
        bus.cpu_fb_we    = 1'b1;
        bus.cpu_fb_addr  = 20'($urandom);
        bus.cpu_fb_wdata = $urandom;
      end
    end
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] e, string tag);
    bus.cfg_addr = a;
    #1;
    chk(tag, bus.cfg_rdata, e);
  endtask

  // Program a rectangle and build its expected raster-order pixel list.
  task automatic setup(int x0, int y0, int x1, int y1, logic [31:0] c);
    wr(3'd0, x0);
    wr(3'd1, y0);
    wr(3'd2, x1);
    wr(3'd3, y1);
    wr(3'd4, c);
    exp_color = c;
    exp_pix.delete();
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        exp_pix.push_back(yy * (1 << X_W) + xx);
  endtask

  task automatic go();
    int n;
    n = cyc;
    wr(3'd5, 32'h1);
    if (exp_pix.size() == 0) done_at = n + 2;
  endtask

  task automatic wait_idle(string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_pix.size() == 0 && !bus.cpu_fb_we && done_at < cyc && !busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_eng(int n, string tag);
    for (int i = 0; i < 100 && eng_cnt < n; i++) tick();
    chk(tag, eng_cnt, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, ry0, rx1, ry1;
    bus.cfg_we       = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_wdata    = '0;
    bus.cpu_fb_we    = 1'b1;
    bus.cpu_fb_addr  = 20'h00abc;
    bus.cpu_fb_wdata = 32'h11111111;
    bus.fb_ready     = 1'b1;

    // Reset state
    #1;
    chk("rst_fb_valid", bus.fb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_irq", done_irq, 1'b0);
    chk("rst_stall", bus.cpu_fb_stall, 1'b1);
    bus.cpu_fb_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, "rst_reg");

    // Test 1: 2x2 fill, timing and addresses
    @(posedge clk);
    #1;
    setup(48, 80, 49, 81, 32'h00ff0000);
    chk("t1_exp0", exp_pix[0], 32'h14030);
    chk("t1_exp3", exp_pix[3], 32'h14431);
    eng_cnt = 0;
    go();
    chk("t1_valid_n1", bus.fb_valid, 1'b0);
    chk("t1_busy_n1", busy, 1'b1);
    tick();
    chk("t1_valid_n2", bus.fb_valid, 1'b1);
    wr(3'd0, 32'd5);
    wait_idle("t1_done");
    chk("t1_beats", eng_cnt, 4);
    rd(3'd5, 32'h2, "t1_ctrl");
    rd(3'd0, 32'd48, "t1_x0_kept");

    // Test 2: empty rectangle
    setup(10, 0, 5, 0, 32'h12345678);
    eng_cnt = 0;
    go();
    chk("t2_busy_n1", busy, 1'b1);
    tick();
    chk("t2_busy_n2", busy, 1'b1);
    tick();
    chk("t2_busy_n3", busy, 1'b0);
    chk("t2_beats", eng_cnt, 0);
    rd(3'd5, 32'h2, "t2_ctrl");

    // Test 3: CPU store during a 16-pixel fill
    setup(100, 200, 103, 203, 32'h0000ff00);
    eng_cnt = 0;
    cpu_cnt = 0;
    go();
    wait_eng(5, "t3_progress");
    bus.cpu_fb_we    = 1'b1;
    bus.cpu_fb_addr  = 20'h00123;
    bus.cpu_fb_wdata = 32'hdeadbeef;
    #1;
    chk("t3_stall", bus.cpu_fb_stall, 1'b0);
    chk("t3_addr", bus.fb_addr, 20'h00123);
    wait_idle("t3_done");
    chk("t3_eng_beats", eng_cnt, 16);
    chk("t3_cpu_beats", cpu_cnt, 1);

    // Test 4: locked engine beat with CPU waiting
    bus.fb_ready = 1'b0;
    setup(7, 3, 8, 3, 32'h0badf00d);
    eng_cnt = 0;
    cpu_cnt = 0;
    go();
    tick();
    chk("t4_eng_valid", bus.fb_valid, 1'b1);
    chk("t4_eng_addr", bus.fb_addr, 20'h00c07);
    tick();
    bus.cpu_fb_we    = 1'b1;
    bus.cpu_fb_addr  = 20'h00456;
    bus.cpu_fb_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_lock_stall", bus.cpu_fb_stall, 1'b1);
      chk("t4_lock_addr", bus.fb_addr, 20'h00c07);
      chk("t4_lock_data", bus.fb_wdata, 32'h0badf00d);
      tick();
    end
    bus.fb_ready = 1'b1;
    #1;
    chk("t4_accept_stall", bus.cpu_fb_stall, 1'b1);
    chk("t4_accept_addr", bus.fb_addr, 20'h00c07);
    tick();
    chk("t4_cpu_next_stall", bus.cpu_fb_stall, 1'b0);
    chk("t4_cpu_next_addr", bus.fb_addr, 20'h00456);
    wait_idle("t4_done");
    chk("t4_eng_beats", eng_cnt, 2);
    chk("t4_cpu_beats", cpu_cnt, 1);

    // Test 5: abort after two beats of a 4x4 fill
    setup(0, 0, 3, 3, 32'h00000077);
    eng_cnt = 0;
    go();
    wait_eng(2, "t5_progress");
    exp_pix.delete();
    wr(3'd5, 32'h2);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_busy", busy, 1'b0);
    chk("t5_beats", eng_cnt, 2);
    rd(3'd5, 32'h4, "t5_ctrl");

    // Randomized fills with random back-pressure and CPU traffic
    rand_on   = 1'b1;
    ready_pct = 70;
    cpu_pct   = 25;
    for (int r = 0; r < 12; r++) begin
      rx0 = $urandom_range(1, 1019);
      ry0 = $urandom_range(1, 1019);
      rx1 = rx0 + $urandom_range(0, 3);
      ry1 = ry0 + $urandom_range(0, 3);
      if (r % 4 == 3) rx1 = rx0 - 1;
      setup(rx0, ry0, rx1, ry1, $urandom);
      go();
      wait_idle("rnd_done");
    end
    rand_on      = 1'b0;
    bus.fb_ready = 1'b1;
    wait_idle("rnd_drain");

    // Reset in the middle of a fill
    setup(0, 0, 3, 3, 32'h55aa55aa);
    eng_cnt = 0;
    go();
    wait_eng(3, "t6_progress");
    bus.cpu_fb_we = 1'b1;
    rst = 1'b0;
    #1;
    chk("t6_fb_valid", bus.fb_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done_irq", done_irq, 1'b0);
    chk("t6_stall", bus.cpu_fb_stall, 1'b1);
    exp_pix.delete();
    done_at = -1;
    tick();
    bus.cpu_fb_we = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) rd(3'(i), 32'h0, "t6_reg");
    for (int i = 0; i < 10; i++) tick();
    chk("t6_busy_after", busy, 1'b0);
    chk("t6_beats", eng_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
